elixirchip_es1_spu_op_mem_sp_arb: RTL and testbench

ELIXIRCHIP_ES1_SPU_OP_MEM_SP_ARB -- requirements
Module: elixirchip_es1_spu_op_mem_sp_arb

---
 rtl/elixirchip_es1_spu_op_mem_sp_arb_pkg.sv | 15 +
 rtl/elixirchip_es1_spu_op_mem_sp_arb_tag_pipe.sv | 31 +++
 rtl/elixirchip_es1_spu_op_mem_sp_arb.sv | 104 ++++++++++
 tb/tb_elixirchip_es1_spu_op_mem_sp_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_op_mem_sp_arb_pkg.sv
// Shared types for the single-port memory arbiter: response tag and port-index sizing.
package elixirchip_es1_spu_op_mem_sp_arb_pkg;

  localparam int TAG_PORT_BITS = 3;

  typedef struct packed {
    logic                     valid;
    logic [TAG_PORT_BITS-1:0] port;
  } tag_t;

  function automatic int port_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_mem_sp_arb_tag_pipe.sv
// Delays read tags by LATENCY enabled cycles so they line up with the memory's read data.
module elixirchip_es1_spu_op_mem_sp_arb_tag_pipe
  import elixirchip_es1_spu_op_mem_sp_arb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic cke,
  input  tag_t in_tag,
  output tag_t out_tag
);

  tag_t stage [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else if (cke) begin
      stage[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_tag = stage[LATENCY-1];

endmodule

// File: rtl/elixirchip_es1_spu_op_mem_sp_arb.sv
// Round-robin arbiter sharing one single-port memory among NUM_PORTS requesters;
// one registered command per enabled cycle, read responses steered back by tag.
module elixirchip_es1_spu_op_mem_sp_arb
  import elixirchip_es1_spu_op_mem_sp_arb_pkg::*;
#(
  parameter int  NUM_PORTS  = 2,
  parameter int  LATENCY    = 1,
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter int  ADDR_BITS  = 8,
  parameter type addr_t     = logic [ADDR_BITS-1:0],
  parameter      DEVICE     = "RTL",
  parameter      SIMULATION = "false",
  parameter      DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic [NUM_PORTS-1:0]  s_valid,
  input  logic [NUM_PORTS-1:0]  s_we,
  input  addr_t [NUM_PORTS-1:0] s_addr,
  input  data_t [NUM_PORTS-1:0] s_wdata,
  output logic [NUM_PORTS-1:0]  s_ready,
  output logic [NUM_PORTS-1:0]  m_rvalid,
  output data_t                 m_rdata,
  output addr_t                 mem_addr,
  output data_t                 mem_wdata,
  output logic                  mem_wvalid,
  input  data_t                 mem_rdata
);

  localparam int PW = port_bits(NUM_PORTS);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  int            idx;
  tag_t          cmd_tag;
  tag_t          rsp_tag;

  // No device-specific variant exists yet; every setting maps onto the generic logic.
  if (DEVICE != "RTL" && SIMULATION != "false" && DEBUG != "false") begin : g_vendor_hook
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!gnt_any && s_valid[PW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (gnt_any && cke && !reset) s_ready[gnt_idx] = 1'b1;
  end

  // Idle cycles still read the held address; the invalid tag suppresses that response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wvalid <= 1'b0;
      cmd_tag    <= '0;
    end else if (cke) begin
      if (gnt_any) begin
        rr_ptr        <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        mem_addr      <= s_addr[gnt_idx];
        mem_wdata     <= s_wdata[gnt_idx];
        mem_wvalid    <= s_we[gnt_idx];
        cmd_tag.valid <= !s_we[gnt_idx];
        cmd_tag.port  <= TAG_PORT_BITS'(gnt_idx);
      end else begin
        mem_wvalid <= 1'b0;
        cmd_tag    <= '0;
      end
    end
  end

  elixirchip_es1_spu_op_mem_sp_arb_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .cke     (cke),
    .in_tag  (cmd_tag),
    .out_tag (rsp_tag)
  );

  always_comb begin
    m_rvalid = '0;
    if (rsp_tag.valid) m_rvalid[rsp_tag.port[PW-1:0]] = 1'b1;
  end

  assign m_rdata = mem_rdata;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mem_sp_arb.sv
// Bench for the single-port memory arbiter: behavioural memory, round-robin/response model.
module tb_elixirchip_es1_spu_op_mem_sp_arb;

  localparam int N   = 2;
  localparam int LAT = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               cke;
  logic [N-1:0]       s_valid;
  logic [N-1:0]       s_we;
  logic [N-1:0][7:0]  s_addr;
  logic [N-1:0][7:0]  s_wdata;
  logic [N-1:0]       s_ready;
  logic [N-1:0]       m_rvalid;
  logic [7:0]         m_rdata;
  logic [7:0]         mem_addr;
  logic [7:0]         mem_wdata;
  logic               mem_wvalid;
  logic [7:0]         mem_rdata;
  logic               mem_init;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_mem_sp_arb #(
    .NUM_PORTS (N),
    .LATENCY   (LAT),
    .DATA_BITS (8),
    .ADDR_BITS (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cke        (cke),
    .s_valid    (s_valid),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_ready    (s_ready),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wvalid (mem_wvalid),
    .mem_rdata  (mem_rdata)
  );

  // Attached single-port memory with LAT cycles of read latency.
  logic [7:0] mem   [256];
  logic [7:0] rpipe [LAT];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
    end else if (cke) begin
      rpipe[0] <= mem[mem_addr];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
      if (mem_wvalid) mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = rpipe[LAT-1];

  // Reference model: arbitration pointer, memory contents, expected responses.
  typedef struct {
    int         due;
    int         port;
    logic [7:0] data;
  } resp_t;

  resp_t      rq [$];
  logic [7:0] refmem [256];
  int         rr;
  int         ecount;
  int         checks;
  int         errors;

  function automatic int pick();
    int p;
    for (int k = 0; k < N; k++) begin
      p = (rr + k) % N;
      if (s_valid[p]) return p;
    end
    return -1;
  endfunction

  task automatic expect_now(output logic [N-1:0] er, output logic [N-1:0] erv,
                            output logic [7:0] ed);
    int g;
    er  = '0;
    erv = '0;
    ed  = '0;
    g   = pick();
    if (g >= 0 && cke && !reset) er[g] = 1'b1;
    if (!reset && rq.size() > 0 && rq[0].due == ecount) begin
      erv[rq[0].port] = 1'b1;
      ed              = rq[0].data;
    end
  endtask

  task automatic advance();
    int g;
    @(posedge clk);
    if (reset) begin
      rq.delete();
      rr = 0;
    end else if (cke) begin
      g = pick();
      if (g >= 0) begin
        rr = (g + 1) % N;
        if (s_we[g]) refmem[s_addr[g]] = s_wdata[g];
        else rq.push_back('{due: ecount + LAT + 1, port: g, data: refmem[s_addr[g]]});
      end
      ecount++;
      while (rq.size() > 0 && rq[0].due < ecount) void'(rq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = '0;
    s_we    = '0;
    s_addr  = '0;
    s_wdata = '0;
    cke     = 1'b1;
  endtask

  task automatic req(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    s_valid[p] = 1'b1;
    s_we[p]    = we;
    s_addr[p]  = a;
    s_wdata[p] = d;
  endtask

  task automatic test_reset();
    logic [N-1:0] er, erv;
    logic [7:0]   ed;
    idle();
    reset    = 1'b1;
    mem_init = 1'b1;
    s_valid  = '1;
    for (int i = 0; i < 256; i++) refmem[i] = 8'(i) ^ 8'h3C;
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    #1;
    expect_now(er, erv, ed);
    checks++; if (s_ready !== er) begin errors++; $display("FAIL reset_ready: got %b want %b", s_ready, er); end
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", m_rvalid); end
    checks++; if (mem_wvalid !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_cmd: got wv=%b a=%h d=%h want 0/00/00", mem_wvalid, mem_addr, mem_wdata);
    end
    advance();
    reset = 1'b0;
    idle();
    advance();
  endtask

  task automatic test_write_read();
    logic [N-1:0] er, erv;
    logic [7:0]   ed, seen;
    int n0, n1, at;
    n0 = 0; n1 = 0; at = -1; seen = '0;
    for (int i = 0; i < LAT + 5; i++) begin
      idle();
      if (i == 0) req(0, 1'b1, 8'h10, 8'h5A);
      if (i == 1) req(1, 1'b0, 8'h10, 8'h00);
      #1;
      expect_now(er, erv, ed);
      checks++; if (s_ready !== er) begin errors++; $display("FAIL wr_rd_ready: got %b want %b", s_ready, er); end
      checks++; if (m_rvalid !== erv || (|erv && m_rdata !== ed)) begin
        errors++; $display("FAIL wr_rd_resp: got %b/%h want %b/%h", m_rvalid, m_rdata, erv, ed);
      end
      if (m_rvalid[1]) begin n1++; at = i; seen = m_rdata; end
      if (m_rvalid[0]) n0++;
      advance();
    end
    checks++; if (n1 != 1 || at != LAT + 2 || seen !== 8'h5A) begin
      errors++; $display("FAIL wr_rd_port1: got n=%0d at=%0d d=%h want 1/%0d/5a", n1, at, LAT + 2, seen);
    end
    checks++; if (n0 != 0) begin errors++; $display("FAIL wr_rd_port0: got %0d pulses want 0", n0); end
  endtask

  task automatic test_alternate();
    logic [N-1:0] er, erv, prev;
    logic [7:0]   ed;
    int hi0;
    hi0 = 0; prev = '0;
    for (int i = 0; i < 12; i++) begin
      idle();
      req(0, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
      req(1, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
      #1;
      expect_now(er, erv, ed);
      checks++; if (s_ready !== er) begin errors++; $display("FAIL alt_ready: got %b want %b", s_ready, er); end
      checks++; if (m_rvalid !== erv || (|erv && m_rdata !== ed)) begin
        errors++; $display("FAIL alt_resp: got %b/%h want %b/%h", m_rvalid, m_rdata, erv, ed);
      end
      if (i > 0) begin
        checks++; if (s_ready === prev || !(s_ready === 2'b01 || s_ready === 2'b10)) begin
          errors++; $display("FAIL alt_toggle: got %b after %b", s_ready, prev);
        end
      end
      if (s_ready[0]) hi0++;
      prev = s_ready;
      advance();
    end
    checks++; if (hi0 != 6) begin errors++; $display("FAIL alt_count: got %0d want 6", hi0); end
    for (int i = 0; i < LAT + 2; i++) begin idle(); advance(); end
  endtask

  task automatic test_cke_stall();
    logic [N-1:0] er, erv;
    logic [7:0]   ed, seen;
    int first, cnt;
    first = -1; cnt = 0; seen = '0;
    for (int i = 0; i < LAT + 8; i++) begin
      idle();
      if (i == 0) req(0, 1'b0, 8'h10, 8'h00);
      if (i >= 1 && i <= 3) cke = 1'b0;
      #1;
      expect_now(er, erv, ed);
      checks++; if (s_ready !== er) begin errors++; $display("FAIL stall_ready: got %b want %b", s_ready, er); end
      checks++; if (m_rvalid !== erv || (|erv && m_rdata !== ed)) begin
        errors++; $display("FAIL stall_resp: got %b/%h want %b/%h", m_rvalid, m_rdata, erv, ed);
      end
      if (m_rvalid[0]) begin cnt++; if (first < 0) begin first = i; seen = m_rdata; end end
      advance();
    end
    checks++; if (first != LAT + 4 || cnt != 1 || seen !== 8'h5A) begin
      errors++; $display("FAIL stall_timing: got at=%0d n=%0d d=%h want %0d/1/5a", first, cnt, seen, LAT + 4);
    end
  endtask

  task automatic test_reset_inflight();
    logic [N-1:0] er, erv;
    logic [7:0]   ed;
    for (int i = 0; i < 2; i++) begin
      idle();
      req(i, 1'b0, 8'(8'h30 + i), 8'h00);
      advance();
    end
    idle();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      idle();
      #1;
      expect_now(er, erv, ed);
      checks++; if (m_rvalid !== 2'b00 || erv !== 2'b00) begin
        errors++; $display("FAIL rst_flight_rvalid: got %b want 00", m_rvalid);
      end
      checks++; if (mem_wvalid !== 1'b0) begin errors++; $display("FAIL rst_flight_wvalid: got %b want 0", mem_wvalid); end
      advance();
    end
  endtask

  task automatic test_write_ff();
    logic [N-1:0] er, erv;
    logic [7:0]   ed, seen;
    int n0;
    n0 = 0; seen = '0;
    for (int i = 0; i < LAT + 5; i++) begin
      idle();
      if (i == 0) req(1, 1'b1, 8'hFF, 8'hA5);
      if (i == 1) req(0, 1'b0, 8'hFF, 8'h00);
      #1;
      expect_now(er, erv, ed);
      checks++; if (m_rvalid !== erv || (|erv && m_rdata !== ed)) begin
        errors++; $display("FAIL wr_ff_resp: got %b/%h want %b/%h", m_rvalid, m_rdata, erv, ed);
      end
      if (m_rvalid[0]) begin n0++; seen = m_rdata; end
      advance();
    end
    checks++; if (n0 != 1 || seen !== 8'hA5) begin
      errors++; $display("FAIL wr_ff_data: got n=%0d d=%h want 1/a5", n0, seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] er, erv;
    logic [7:0]   ed;
    int first, cnt, bad;
    first = -1; cnt = 0; bad = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      idle();
      if (i < 4) req(1, 1'b0, 8'(8'h20 + i), 8'h00);
      #1;
      expect_now(er, erv, ed);
      if (i < 4) begin
        checks++; if (s_ready !== 2'b10) begin errors++; $display("FAIL b2b_ready: got %b want 10", s_ready); end
      end
      checks++; if (m_rvalid !== erv || (|erv && m_rdata !== ed)) begin
        errors++; $display("FAIL b2b_resp: got %b/%h want %b/%h", m_rvalid, m_rdata, erv, ed);
      end
      if (m_rvalid[1]) begin
        if (first < 0) first = i;
        if (i != first + cnt || m_rdata !== (8'(8'h20 + cnt) ^ 8'h3C)) bad++;
        cnt++;
      end
      advance();
    end
    checks++; if (cnt != 4 || first != LAT + 1 || bad != 0) begin
      errors++; $display("FAIL b2b_pulses: got n=%0d at=%0d bad=%0d want 4/%0d/0", cnt, first, bad, LAT + 1);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er, erv;
    logic [7:0]   ed;
    for (int i = 0; i < 400; i++) begin
      idle();
      cke = ($urandom_range(0, 9) != 0);
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 2) != 0) req(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      end
      #1;
      expect_now(er, erv, ed);
      checks++; if (s_ready !== er) begin errors++; $display("FAIL rand_ready: cyc %0d got %b want %b", i, s_ready, er); end
      checks++; if (m_rvalid !== erv || (|erv && m_rdata !== ed)) begin
        errors++; $display("FAIL rand_resp: cyc %0d got %b/%h want %b/%h", i, m_rvalid, m_rdata, erv, ed);
      end
      advance();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rr     = 0;
    ecount = 0;
    test_reset();
    test_write_read();
    test_alternate();
    test_cke_stall();
    test_reset_inflight();
    test_write_ff();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
